// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared miniRISC register-file types and constants
//
// Purpose: default sizes and common types for the register file and its
//          read ports.
// Contents: WIDTH_DEF, NREG_DEF, AW_DEF, ZERO_REG, reg_addr_t, word_t.
package riscv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NREG_DEF  = 32;
    localparam int AW_DEF    = 5;
    localparam int ZERO_REG  = 0;

    typedef logic [AW_DEF-1:0]    reg_addr_t;
    typedef logic [WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/reg_rd_port.sv
// rtl/reg_rd_port.sv - one register-file read port with write bypass and busy
//
// Purpose: selects the value decode sees for one source operand and reports
//          whether that operand is still waiting on a multi-cycle producer.
// Ports:
//   rd_addr_i  in  AW     source register address
//   stored_i   in  WIDTH  array contents at rd_addr_i
//   pend_i     in  1      scoreboard bit for rd_addr_i
//   wr_en_i    in  1      writeback strobe
//   wr_addr_i  in  AW     writeback destination
//   wr_data_i  in  WIDTH  writeback data
//   rd_data_o  out WIDTH  operand value (combinational)
//   busy_o     out 1      operand has an outstanding write (combinational)
module reg_rd_port
    import riscv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic [AW-1:0]    rd_addr_i,
    input  logic [WIDTH-1:0] stored_i,
    input  logic             pend_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             busy_o
);

    logic is_zero;
    logic wr_hit;

    assign is_zero = (rd_addr_i == AW'(ZERO_REG));
    assign wr_hit  = wr_en_i && (wr_addr_i == rd_addr_i);

    always_comb begin
        rd_data_o = stored_i;
        if (is_zero) begin
            rd_data_o = '0;
        end else if (wr_hit) begin
            rd_data_o = wr_data_i;
        end
    end

    // A write landing this cycle is forwarded, so it resolves the hazard.
    assign busy_o = pend_i && !wr_hit && !is_zero;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - miniRISC register file with bypass and pending-write scoreboard
//
// Purpose: two combinational read ports and one writeback port, plus a
//          per-register pending bit set by multi-cycle producers and cleared
//          by their writeback; decode stalls on a consumed busy operand.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data      writeback write port
//   rd_addr_a/b, rd_use_a/b      decode source addresses and consume flags
//   rd_data_a/b                  source values (combinational)
//   pend_set_en, pend_set_addr   mark a destination as pending
//   busy_a/b, stall              hazard outputs (combinational)
//   pend_count                   registered number of pending registers
module reg_file_sb
    import riscv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    input  logic             rd_use_a,
    input  logic             rd_use_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             pend_set_en,
    input  logic [AW-1:0]    pend_set_addr,
    output logic             busy_a,
    output logic             busy_b,
    output logic             stall,
    output logic [AW:0]      pend_count
);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [NREG-1:0]  pend_q;
    logic [NREG-1:0]  pend_d;
    logic [AW:0]      pend_count_q;
    logic [AW:0]      pend_count_d;

    logic wr_ok;
    logic set_ok;

    assign wr_ok  = wr_en && (wr_addr != AW'(ZERO_REG));
    assign set_ok = pend_set_en && (pend_set_addr != AW'(ZERO_REG));

    // Clear first, then set: a new producer on the same register supersedes
    // the one whose result is arriving now.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (set_ok) begin
            pend_d[pend_set_addr] = 1'b1;
        end
        pend_d[ZERO_REG] = 1'b0;
    end

    always_comb begin
        pend_count_d = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_count_d = pend_count_d + {{AW{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pend_q       <= '0;
            pend_count_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[wr_addr] <= wr_data;
            end
            pend_q       <= pend_d;
            pend_count_q <= pend_count_d;
        end
    end

    assign pend_count = pend_count_q;

    reg_rd_port #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_port_a (
        .rd_addr_i (rd_addr_a),
        .stored_i  (regs_q[rd_addr_a]),
        .pend_i    (pend_q[rd_addr_a]),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_data_o (rd_data_a),
        .busy_o    (busy_a)
    );

    reg_rd_port #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_port_b (
        .rd_addr_i (rd_addr_b),
        .stored_i  (regs_q[rd_addr_b]),
        .pend_i    (pend_q[rd_addr_b]),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_data_o (rd_data_b),
        .busy_o    (busy_b)
    );

    assign stall = (rd_use_a && busy_a) || (rd_use_b && busy_b);

endmodule
